// File: rtl/dm_byte_access_unit_if.sv
// ============================================================================
// Module      : dm_byte_access_unit_if
// Description : Request/response bus between the M stage and the data-memory
//               byte access unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dm_byte_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        mem_write;
   logic [1:0]  be_op;
   logic [2:0]  ld_op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        resp_valid;
   logic        resp_err;

   // M stage side: issues requests, receives responses
   modport master (
      output req_valid, mem_write, be_op, ld_op, addr, wdata,
      input  req_ready, rdata, resp_valid, resp_err
   );

   // Memory side: accepts requests, produces responses
   modport slave (
      input  req_valid, mem_write, be_op, ld_op, addr, wdata,
      output req_ready, rdata, resp_valid, resp_err
   );
endinterface

`default_nettype wire

// File: rtl/dm_byte_access_unit.sv
// ============================================================================
// Module      : dm_byte_access_unit
// Description : Word-wide data RAM with byte/halfword/word stores and
//               zero/sign-extended loads behind a valid/ready request and a
//               one-cycle response pulse. IDLE -> ACCESS (WAIT_CYCLES+1) -> RESP.
//               Optional macro DM_TRACE_EN: prints every committed store.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_byte_access_unit #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 0
) (
   input  wire logic             clk,
   input  wire logic             reset,
   dm_byte_access_unit_if.slave  bif
);

   localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);
   localparam int         C_AW   = ADDR_WIDTH + 2;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              mem_write_q, mem_write_d;
   logic [1:0]        be_op_q, be_op_d;
   logic [2:0]        ld_op_q, ld_op_d;
   logic [C_AW-1:0]   addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              resp_err_q, resp_err_d;

   logic [31:0]       ram_q [0:(2**ADDR_WIDTH)-1];

   logic [ADDR_WIDTH-1:0] w_idx;
   logic [31:0]       w_rd_word;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic              w_err;
   logic [3:0]        w_be;
   logic [31:0]       w_wd;
   logic [31:0]       w_ld_val;
   logic              w_wr_en;

   // Address bits above the RAM are deliberately discarded (wrap-around).
   logic              unused_addr_hi;
   assign unused_addr_hi = ^bif.addr[31:C_AW];

   assign w_idx          = addr_q[C_AW-1:2];
   assign w_rd_word      = ram_q[w_idx];
   assign bif.req_ready  = (state_q == S_IDLE);
   assign bif.resp_valid = (state_q == S_RESP);
   assign bif.rdata      = rdata_q;
   assign bif.resp_err   = resp_err_q;

   // Decode captured request: lane enables, replicated store data, load value, error
   always_comb begin
      w_err    = 1'b0;
      w_be     = 4'b0000;
      w_wd     = wdata_q;
      w_ld_val = 32'h0;
      case (addr_q[1:0])
         2'd0:    w_byte = w_rd_word[7:0];
         2'd1:    w_byte = w_rd_word[15:8];
         2'd2:    w_byte = w_rd_word[23:16];
         default: w_byte = w_rd_word[31:24];
      endcase
      w_half = addr_q[1] ? w_rd_word[31:16] : w_rd_word[15:0];
      if (mem_write_q) begin
         case (be_op_q)
            2'b00: begin
               w_err = (addr_q[1:0] != 2'b00);
               w_be  = 4'b1111;
            end
            2'b01: begin
               w_be = 4'b0001 << addr_q[1:0];
               w_wd = {4{wdata_q[7:0]}};
            end
            2'b10: begin
               w_err = addr_q[0];
               w_be  = addr_q[1] ? 4'b1100 : 4'b0011;
               w_wd  = {2{wdata_q[15:0]}};
            end
            default: w_err = 1'b1;
         endcase
      end else begin
         case (ld_op_q)
            3'b000: begin
               w_err    = (addr_q[1:0] != 2'b00);
               w_ld_val = w_rd_word;
            end
            3'b001: w_ld_val = {24'h0, w_byte};
            3'b010: w_ld_val = {{24{w_byte[7]}}, w_byte};
            3'b011: begin
               w_err    = addr_q[0];
               w_ld_val = {16'h0, w_half};
            end
            3'b100: begin
               w_err    = addr_q[0];
               w_ld_val = {{16{w_half[15]}}, w_half};
            end
            default: w_err = 1'b1;
         endcase
      end
   end

   // Next-state, request capture and commit control
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_write_d = mem_write_q;
      be_op_d     = be_op_q;
      ld_op_d     = ld_op_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      resp_err_d  = resp_err_q;
      w_wr_en     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bif.req_valid) begin
               mem_write_d = bif.mem_write;
               be_op_d     = bif.be_op;
               ld_op_d     = bif.ld_op;
               addr_d      = bif.addr[C_AW-1:0];
               wdata_d     = bif.wdata;
               cnt_d       = 4'd0;
               state_d     = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (cnt_q == C_WAIT) begin
               w_wr_en    = mem_write_q & ~w_err;
               rdata_d    = (mem_write_q | w_err) ? 32'h0 : w_ld_val;
               resp_err_d = w_err;
               state_d    = S_RESP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Control and response registers; async reset aborts any pending commit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         mem_write_q <= 1'b0;
         be_op_q     <= 2'b00;
         ld_op_q     <= 3'b000;
         addr_q      <= '0;
         wdata_q     <= 32'h0;
         rdata_q     <= 32'h0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_write_q <= mem_write_d;
         be_op_q     <= be_op_d;
         ld_op_q     <= ld_op_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         resp_err_q  <= resp_err_d;
      end
   end

   // RAM lane writes; contents survive reset
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) ram_q[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
         end
      end
   end

`ifdef DM_TRACE_EN
   logic [31:0] w_merged;

   // Word as it will look after the lane merge
   always_comb begin
      w_merged = w_rd_word;
      for (int i = 0; i < 4; i++) begin
         if (w_be[i]) w_merged[8*i +: 8] = w_wd[8*i +: 8];
      end
   end

   // Store trace
   always_ff @(posedge clk) begin
      if (w_wr_en) $display("%0t dm store addr=%h data=%h", $time, {addr_q[C_AW-1:2], 2'b00}, w_merged);
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dm_byte_access_unit.sv
// ============================================================================
// Module      : tb_dm_byte_access_unit
// Description : Directed self-checking bench; one instance with no stall and
//               one with WAIT_CYCLES=3 for wrap, stall and reset-abort cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_byte_access_unit;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dm_byte_access_unit_if bus0 ();
   dm_byte_access_unit_if bus3 ();

   dm_byte_access_unit #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bif   (bus0.slave)
   );

   dm_byte_access_unit #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u_dut3 (
      .clk   (clk),
      .reset (reset),
      .bif   (bus3.slave)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic ready(input int sel);
      return (sel == 0) ? bus0.req_ready : bus3.req_ready;
   endfunction

   function automatic logic resp(input int sel);
      return (sel == 0) ? bus0.resp_valid : bus3.resp_valid;
   endfunction

   function automatic logic [31:0] rdat(input int sel);
      return (sel == 0) ? bus0.rdata : bus3.rdata;
   endfunction

   function automatic logic rerr(input int sel);
      return (sel == 0) ? bus0.resp_err : bus3.resp_err;
   endfunction

   task automatic drive(input int sel, input logic v, input logic mw, input logic [1:0] be,
                        input logic [2:0] ld, input logic [31:0] a, input logic [31:0] wd);
      if (sel == 0) begin
         bus0.req_valid = v; bus0.mem_write = mw; bus0.be_op = be;
         bus0.ld_op = ld; bus0.addr = a; bus0.wdata = wd;
      end else begin
         bus3.req_valid = v; bus3.mem_write = mw; bus3.be_op = be;
         bus3.ld_op = ld; bus3.addr = a; bus3.wdata = wd;
      end
   endtask

   // Wait for an idle unit and present one request for the accept edge.
   task automatic issue(input int sel, input logic mw, input logic [1:0] be,
                        input logic [2:0] ld, input logic [31:0] a, input logic [31:0] wd);
      int n;
      n = 0;
      while (!ready(sel) && n < 40) begin
         @(posedge clk); #1; n++;
      end
      drive(sel, 1'b1, mw, be, ld, a, wd);
      @(posedge clk); #1;
      drive(sel, 1'b0, 1'b0, 2'b00, 3'b000, 32'hFFFF_FFFF, 32'h5A5A_5A5A);
   endtask

   // Full transaction: latency, response data/error, single-cycle pulse, hold.
   task automatic access(input string tag, input int sel, input logic mw, input logic [1:0] be,
                         input logic [2:0] ld, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
      int n;
      int w;
      w = (sel == 0) ? 0 : 3;
      issue(sel, mw, be, ld, a, wd);
      check({tag, " busy"}, 32'(ready(sel)), 32'd0);
      @(posedge clk); #1;
      n = 1;
      while (!resp(sel) && n < 40) begin
         @(posedge clk); #1; n++;
      end
      // seen just after edge W+1, i.e. first sampled high by edge W+2
      check({tag, " lat"}, 32'(n), 32'(w + 1));
      check({tag, " rdata"}, rdat(sel), exp_rd);
      check({tag, " err"}, 32'(rerr(sel)), 32'(exp_err));
      @(posedge clk); #1;
      check({tag, " pulse"}, 32'(resp(sel)), 32'd0);
      check({tag, " hold"}, rdat(sel), exp_rd);
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
      drive(3, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check("rst ready", 32'(bus0.req_ready), 32'd1);
      check("rst resp", 32'(bus0.resp_valid), 32'd0);
      check("rst err", 32'(bus0.resp_err), 32'd0);
      check("rst rdata", bus0.rdata, 32'h0);
      check("rst ready3", 32'(bus3.req_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;

      // word store/load
      access("sw10", 0, 1'b1, 2'b00, 3'b000, 32'h10, 32'h1234_5678, 32'h0, 1'b0);
      access("lw10", 0, 1'b0, 2'b00, 3'b000, 32'h10, 32'h0, 32'h1234_5678, 1'b0);

      // byte store and loads
      access("sw20", 0, 1'b1, 2'b00, 3'b000, 32'h20, 32'h0, 32'h0, 1'b0);
      access("sb21", 0, 1'b1, 2'b01, 3'b000, 32'h21, 32'h0000_00AB, 32'h0, 1'b0);
      access("lw20a", 0, 1'b0, 2'b00, 3'b000, 32'h20, 32'h0, 32'h0000_AB00, 1'b0);
      access("lb21", 0, 1'b0, 2'b00, 3'b010, 32'h21, 32'h0, 32'hFFFF_FFAB, 1'b0);
      access("lbu21", 0, 1'b0, 2'b00, 3'b001, 32'h21, 32'h0, 32'h0000_00AB, 1'b0);

      // halfword store and loads
      access("sw20b", 0, 1'b1, 2'b00, 3'b000, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
      access("sh22", 0, 1'b1, 2'b10, 3'b000, 32'h22, 32'h0000_8001, 32'h0, 1'b0);
      access("lw20b", 0, 1'b0, 2'b00, 3'b000, 32'h20, 32'h0, 32'h8001_3344, 1'b0);
      access("lh22", 0, 1'b0, 2'b00, 3'b100, 32'h22, 32'h0, 32'hFFFF_8001, 1'b0);
      access("lhu22", 0, 1'b0, 2'b00, 3'b011, 32'h22, 32'h0, 32'h0000_8001, 1'b0);
      access("lbu23", 0, 1'b0, 2'b00, 3'b001, 32'h23, 32'h0, 32'h0000_0080, 1'b0);

      // misalignment and reserved ops
      access("sw13", 0, 1'b1, 2'b00, 3'b000, 32'h13, 32'hFFFF_FFFF, 32'h0, 1'b1);
      access("lw10b", 0, 1'b0, 2'b00, 3'b000, 32'h10, 32'h0, 32'h1234_5678, 1'b0);
      access("lh21", 0, 1'b0, 2'b00, 3'b100, 32'h21, 32'h0, 32'h0, 1'b1);
      access("sw40", 0, 1'b1, 2'b00, 3'b000, 32'h40, 32'h0BAD_F00D, 32'h0, 1'b0);
      access("be11", 0, 1'b1, 2'b11, 3'b000, 32'h40, 32'h0000_0055, 32'h0, 1'b1);
      access("lw40", 0, 1'b0, 2'b00, 3'b000, 32'h40, 32'h0, 32'h0BAD_F00D, 1'b0);
      access("ld101", 0, 1'b0, 2'b00, 3'b101, 32'h40, 32'h0, 32'h0, 1'b1);

      // wrap and stall
      access("sw1004", 3, 1'b1, 2'b00, 3'b000, 32'h1004, 32'hCAFE_F00D, 32'h0, 1'b0);
      access("lw4", 3, 1'b0, 2'b00, 3'b000, 32'h4, 32'h0, 32'hCAFE_F00D, 1'b0);

      // reset during ACCESS drops the store
      access("sw30", 3, 1'b1, 2'b00, 3'b000, 32'h30, 32'h1111_1111, 32'h0, 1'b0);
      access("lw4h", 3, 1'b0, 2'b00, 3'b000, 32'h4, 32'h0, 32'hCAFE_F00D, 1'b0);
      issue(3, 1'b1, 2'b00, 3'b000, 32'h30, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("rstmid ready", 32'(bus3.req_ready), 32'd1);
      check("rstmid resp", 32'(bus3.resp_valid), 32'd0);
      check("rstmid rdata", bus3.rdata, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      access("lw30", 3, 1'b0, 2'b00, 3'b000, 32'h30, 32'h0, 32'h1111_1111, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
